// File: rtl/pipe_pkg.sv
// Shared types and helpers for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int unsigned FIELD_MAX_W = 64;
  localparam int unsigned BUS_MAX_W   = 1024;

  // Field k of a packed bus whose fields are w bits wide (w up to FIELD_MAX_W).
  function automatic logic [FIELD_MAX_W-1:0] get_field(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          k,
    input int unsigned          w
  );
    logic [BUS_MAX_W-1:0]   sh;
    logic [FIELD_MAX_W-1:0] mask;
    sh = bus >> (k * w);
    if (w >= FIELD_MAX_W) mask = '1;
    else mask = ({{(FIELD_MAX_W-1){1'b0}}, 1'b1} << w) - {{(FIELD_MAX_W-1){1'b0}}, 1'b1};
    return sh[FIELD_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready handshake bundle for both sides of one pipeline stage.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 5
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_FIELDS*DATA_W-1:0] in_data;
  logic [31:0]                  in_inst;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_FIELDS*DATA_W-1:0] out_data;
  logic [31:0]                  out_inst;

  // The stage itself: consumes the upstream beat, produces the downstream beat.
  modport slave (
    input  in_valid, in_data, in_inst, out_ready,
    output in_ready, out_valid, out_data, out_inst
  );

  // Whatever surrounds the stage: producer upstream and consumer downstream.
  modport master (
    output in_valid, in_data, in_inst, out_ready,
    input  in_ready, out_valid, out_data, out_inst
  );
endinterface

// File: rtl/pipe_stage_slot.sv
// One storage entry (data + instruction tag) of the pipeline stage.
// A flush re-tags the entry as a NOP but leaves the data bits untouched.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int          W        = 160,
  parameter logic [31:0] NOP_INST = RV_NOP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  input  logic [31:0]  inst_i,
  output logic [W-1:0] data_o,
  output logic [31:0]  inst_o
);

  logic [W-1:0] data_q;
  logic [31:0]  inst_q;

  // Data payload: loads on enable, never cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_q <= '0;
    else if (ld_i && !flush_i) data_q <= data_i;
  end

  // Instruction tag: flush wins over load so a killed beat reads as a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          inst_q <= NOP_INST;
    else if (flush_i) inst_q <= NOP_INST;
    else if (ld_i)    inst_q <= inst_i;
  end

  assign data_o = data_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Parametrised pipeline register with valid/ready handshake, 2-entry skid
// buffer, global stall hold and synchronous flush.
// Optional build macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
//
// state    | meaning
// ST_EMPTY | no beat held, out_valid low
// ST_FULL  | main entry holds a beat
// ST_SKID  | main and skid entries both hold beats, upstream blocked
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          NUM_FIELDS = 5,
  parameter logic [31:0] NOP_INST   = RV_NOP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  pipe_stage_skid_reg_if.slave  bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt
`endif
);

  localparam int BUS_W = NUM_FIELDS * DATA_W;

  pipe_state_e state_q, state_d;

  logic             in_ready;
  logic             out_valid;
  logic             acc, deq;
  logic             main_ld_d, skid_ld_d, main_from_skid_d;
  logic [BUS_W-1:0] main_data, skid_data, main_data_in;
  logic [31:0]      main_inst, skid_inst, main_inst_in;

  // in_ready comes straight from the state register and stall, never from out_ready.
  assign in_ready  = (state_q != ST_SKID) && !stall;
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = bus.in_valid && in_ready;
  assign deq       = out_valid && bus.out_ready && !stall;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next state and entry load enables; flush overrides everything, stall freezes.
  always_comb begin
    state_d          = state_q;
    main_ld_d        = 1'b0;
    skid_ld_d        = 1'b0;
    main_from_skid_d = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (!stall) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d   = ST_FULL;
            main_ld_d = 1'b1;
          end
        end
        ST_FULL: begin
          if (acc && deq) begin
            main_ld_d = 1'b1;
          end else if (acc) begin
            state_d   = ST_SKID;
            skid_ld_d = 1'b1;
          end else if (deq) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (deq) begin
            state_d          = ST_FULL;
            main_ld_d        = 1'b1;
            main_from_skid_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_data_in = main_from_skid_d ? skid_data : bus.in_data;
  assign main_inst_in = main_from_skid_d ? skid_inst : bus.in_inst;

  pipe_stage_slot #(.W(BUS_W), .NOP_INST(NOP_INST)) u_main (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (main_ld_d),
    .flush_i (flush),
    .data_i  (main_data_in),
    .inst_i  (main_inst_in),
    .data_o  (main_data),
    .inst_o  (main_inst)
  );

  pipe_stage_slot #(.W(BUS_W), .NOP_INST(NOP_INST)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (skid_ld_d),
    .flush_i (flush),
    .data_i  (bus.in_data),
    .inst_i  (bus.in_inst),
    .data_o  (skid_data),
    .inst_o  (skid_inst)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_data;
  assign bus.out_inst  = main_inst;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Stall counter: one per stalled cycle, sticks at all-ones; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  // Bubble counter: downstream ready but nothing to give it, outside of stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= '0;
    else if (bus.out_ready && !out_valid && !stall && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
